// File: rtl/alu_pkg.sv
// Shared definitions for the ALU pipeline: opcodes, flag bit positions,
// the control state encoding and a flag-packing helper.
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0001;
  localparam logic [3:0] OP_OR    = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_ADDCU = 4'b0100;
  localparam logic [3:0] OP_ADD   = 4'b0101;
  localparam logic [3:0] OP_ADDU  = 4'b0110;
  localparam logic [3:0] OP_ADDC  = 4'b0111;
  localparam logic [3:0] OP_MUL   = 4'b1000;
  localparam logic [3:0] OP_SUB   = 4'b1001;
  localparam logic [3:0] OP_CMP   = 4'b1011;
  localparam logic [3:0] OP_LSH   = 4'b1100;
  localparam logic [3:0] OP_RSH   = 4'b1101;
  localparam logic [3:0] OP_ALSH  = 4'b1110;
  localparam logic [3:0] OP_ARSH  = 4'b1111;

  localparam int FLAG_N = 0;
  localparam int FLAG_L = 1;
  localparam int FLAG_F = 2;
  localparam int FLAG_C = 3;
  localparam int FLAG_Z = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  function automatic logic [4:0] mk_flags(input logic z, input logic c, input logic f,
                                          input logic l, input logic n);
    logic [4:0] r;
    r         = 5'b00000;
    r[FLAG_Z] = z;
    r[FLAG_C] = c;
    r[FLAG_F] = f;
    r[FLAG_L] = l;
    r[FLAG_N] = n;
    return r;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier, one multiplier bit per cycle.
// product presents the value the final iteration will write, so done and product line up.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE_CNT  = {{(CW-1){1'b0}}, 1'b1};

  logic [2*WIDTH-1:0] mcand_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] addend_s;
  logic [WIDTH-1:0]   mplier_r;
  logic [CW-1:0]      cnt_r;
  logic               busy_r;

  assign addend_s = mplier_r[0] ? mcand_r : {(2*WIDTH){1'b0}};
  assign product  = acc_r + addend_s;
  assign done     = busy_r && (cnt_r == LAST_CNT);

  // Operand capture on start, then one shift-add step per cycle while busy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand_r  <= '0;
      acc_r    <= '0;
      mplier_r <= '0;
      cnt_r    <= '0;
      busy_r   <= 1'b0;
    end else if (start) begin
      mcand_r  <= {{WIDTH{1'b0}}, a};
      acc_r    <= '0;
      mplier_r <= b;
      cnt_r    <= '0;
      busy_r   <= 1'b1;
    end else if (busy_r) begin
      acc_r    <= product;
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      cnt_r    <= cnt_r + ONE_CNT;
      busy_r   <= !done;
    end else begin
      busy_r   <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// ALU with registered result/flags: single-cycle logic, add, compare and shift ops,
// plus an optional multi-cycle multiply. out_valid pulses once per accepted operation.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  input  logic             psr_we,
  input  logic [4:0]       psr_wdata,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       flags
);
  localparam logic [WIDTH-1:0] SHIFT_LIMIT = WIDTH'(WIDTH);

  state_t             state_r;
  logic [WIDTH-1:0]   result_r;
  logic [4:0]         flags_r;
  logic               out_valid_r;
  logic [WIDTH-1:0]   alu_res_s;
  logic [4:0]         alu_flags_s;
  logic               is_mul_s;
  logic               illegal_s;
  logic               cin_s;
  logic [WIDTH:0]     sum_s;
  logic [WIDTH-1:0]   diff_s;
  logic               add_ovf_s;
  logic               sub_ovf_s;
  logic               mul_start_s;
  logic               mul_done_s;
  logic [2*WIDTH-1:0] mul_product_s;

  assign in_ready  = (state_r == ST_IDLE);
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign flags     = flags_r;

  // Carry-in comes from the registered C flag, so chained adds see the previous op's carry.
  assign cin_s     = ((opcode == OP_ADDC) || (opcode == OP_ADDCU)) && flags_r[FLAG_C];
  assign sum_s     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin_s};
  assign diff_s    = a - b;
  assign add_ovf_s = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
  assign sub_ovf_s = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
  assign mul_start_s = in_valid && in_ready && is_mul_s;

  // Single-cycle result and flag computation from the presented operands.
  always_comb begin
    alu_res_s   = '0;
    alu_flags_s = 5'b00000;
    is_mul_s    = 1'b0;
    illegal_s   = 1'b0;
    case (opcode)
      OP_AND, OP_OR, OP_XOR: begin
        if (opcode == OP_AND) alu_res_s = a & b;
        else if (opcode == OP_OR) alu_res_s = a | b;
        else alu_res_s = a ^ b;
        alu_flags_s = mk_flags(alu_res_s == '0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      OP_ADDU, OP_ADDCU: begin
        alu_res_s   = sum_s[WIDTH-1:0];
        alu_flags_s = mk_flags(alu_res_s == '0, sum_s[WIDTH], 1'b0, 1'b0, 1'b0);
      end
      OP_ADD, OP_ADDC: begin
        alu_res_s   = sum_s[WIDTH-1:0];
        alu_flags_s = mk_flags(alu_res_s == '0, 1'b0, add_ovf_s, 1'b0, 1'b0);
      end
      OP_SUB: begin
        alu_res_s   = diff_s;
        alu_flags_s = mk_flags(alu_res_s == '0, 1'b0, sub_ovf_s, 1'b0, 1'b0);
      end
      OP_CMP: begin
        alu_flags_s = mk_flags(a == b, 1'b0, 1'b0, a < b, $signed(a) < $signed(b));
      end
      OP_LSH, OP_ALSH: begin
        if (b >= SHIFT_LIMIT) alu_res_s = '0;
        else alu_res_s = a << b;
      end
      OP_RSH: begin
        if (b >= SHIFT_LIMIT) alu_res_s = '0;
        else alu_res_s = a >> b;
      end
      OP_ARSH: begin
        if (b >= SHIFT_LIMIT) alu_res_s = {WIDTH{a[WIDTH-1]}};
        else alu_res_s = $unsigned($signed(a) >>> b);
      end
      OP_MUL: begin
        if (MUL_EN != 0) is_mul_s = 1'b1;
        else illegal_s = 1'b1;
      end
      default: illegal_s = 1'b1;
    endcase
  end

  // Control state, registered outputs and flag register; a psr write overrides op flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      result_r    <= '0;
      flags_r     <= 5'b00000;
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (in_valid && is_mul_s) begin
            state_r <= ST_MUL;
          end else if (in_valid) begin
            result_r    <= alu_res_s;
            out_valid_r <= 1'b1;
            if (!illegal_s) flags_r <= alu_flags_s;
          end
        end
        ST_MUL: begin
          if (mul_done_s) begin
            state_r     <= ST_IDLE;
            result_r    <= mul_product_s[WIDTH-1:0];
            out_valid_r <= 1'b1;
            flags_r     <= mk_flags(mul_product_s[WIDTH-1:0] == '0,
                                    mul_product_s[2*WIDTH-1:WIDTH] != '0,
                                    1'b0, 1'b0, 1'b0);
          end
        end
        default: state_r <= ST_IDLE;
      endcase
      if (psr_we) flags_r <= psr_wdata;
    end
  end

  generate
    if (MUL_EN != 0) begin : g_mul
      alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (mul_start_s),
        .a       (a),
        .b       (b),
        .done    (mul_done_s),
        .product (mul_product_s)
      );
    end else begin : g_no_mul
      assign mul_done_s    = 1'b0;
      assign mul_product_s = '0;
    end
  endgenerate

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: expectations are queued at acceptance and
// compared when out_valid pulses; directed cases first, then random traffic.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int W = 16;

  typedef struct packed {
    logic [15:0] res;
    logic [4:0]  flg;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   opcode = 4'b0000;
  logic         psr_we = 1'b0;
  logic [4:0]   psr_wdata = 5'b00000;
  logic         out_valid;
  logic [W-1:0] result;
  logic [4:0]   flags;

  exp_t       sbq[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         ov_count = 0;
  logic [4:0] model_flags = 5'b00000;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W), .MUL_EN(1)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .opcode    (opcode),
    .psr_we    (psr_we),
    .psr_wdata (psr_wdata),
    .out_valid (out_valid),
    .result    (result),
    .flags     (flags)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model written in plain integer arithmetic; flags are {Z,C,F,L,N}.
  function automatic exp_t model(input logic [3:0] op, input logic [15:0] x,
                                 input logic [15:0] y, input logic [4:0] fin);
    exp_t        e;
    int          sx, sy, sr;
    logic [16:0] s17;
    logic [31:0] p;
    e.res = 16'h0000;
    e.flg = 5'b00000;
    sx = int'($signed(x));
    sy = int'($signed(y));
    case (op)
      OP_AND: begin e.res = x & y; e.flg[4] = (e.res == 16'h0000); end
      OP_OR:  begin e.res = x | y; e.flg[4] = (e.res == 16'h0000); end
      OP_XOR: begin e.res = x ^ y; e.flg[4] = (e.res == 16'h0000); end
      OP_ADDU, OP_ADDCU: begin
        s17 = {1'b0, x} + {1'b0, y} + ((op == OP_ADDCU) ? {16'h0000, fin[3]} : 17'h00000);
        e.res = s17[15:0];
        e.flg[3] = s17[16];
        e.flg[4] = (e.res == 16'h0000);
      end
      OP_ADD, OP_ADDC, OP_SUB: begin
        if (op == OP_SUB) sr = sx - sy;
        else sr = sx + sy + ((op == OP_ADDC) ? int'(fin[3]) : 0);
        e.res = sr[15:0];
        e.flg[2] = (sr > 32767) || (sr < -32768);
        e.flg[4] = (e.res == 16'h0000);
      end
      OP_CMP: begin
        e.flg[0] = (sx < sy);
        e.flg[1] = (x < y);
        e.flg[4] = (x == y);
      end
      OP_LSH, OP_ALSH: e.res = (y >= 16'd16) ? 16'h0000 : (x << y);
      OP_RSH:          e.res = (y >= 16'd16) ? 16'h0000 : (x >> y);
      OP_ARSH: begin
        if (y >= 16'd16) sr = (sx < 0) ? -1 : 0;
        else sr = sx >>> y;
        e.res = sr[15:0];
      end
      OP_MUL: begin
        p = {16'h0000, x} * {16'h0000, y};
        e.res = p[15:0];
        e.flg[3] = (p[31:16] != 16'h0000);
        e.flg[4] = (p[15:0] == 16'h0000);
      end
      default: e.flg = fin;
    endcase
    return e;
  endfunction

  task automatic send(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y,
                      input logic pw, input logic [4:0] pd);
    exp_t e;
    int   guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) chk("ready_timeout", {31'b0, in_ready}, 32'h1);
    opcode    = op;
    a         = x;
    b         = y;
    psr_we    = pw;
    psr_wdata = pd;
    in_valid  = 1'b1;
    e = model(op, x, y, model_flags);
    if (pw) e.flg = pd;
    model_flags = e.flg;
    sbq.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    psr_we   = 1'b0;
  endtask

  // Output monitor: every out_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset_n && out_valid) begin
      ov_count++;
      if (sbq.size() == 0) begin
        chk("unexpected_out_valid", 32'h1, 32'h0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("result", {16'h0000, result}, {16'h0000, e.res});
        chk("flags", {27'h0, flags}, {27'h0, e.flg});
      end
    end
  end

  initial begin
    int ov_before;
    int guard;
    logic [3:0]  rop;
    logic [15:0] rx, ry;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", {16'h0000, result}, 32'h0);
    chk("rst_flags", {27'h0, flags}, 32'h0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
    reset_n = 1'b1;

    send(OP_ADDU,  16'hFFFF, 16'h0001, 1'b0, 5'b00000);
    send(OP_ADDC,  16'h0001, 16'h0001, 1'b0, 5'b00000);
    send(OP_SUB,   16'h8000, 16'h0001, 1'b0, 5'b00000);
    send(OP_CMP,   16'hFFFF, 16'h0001, 1'b0, 5'b00000);
    send(4'b1010,  16'h1234, 16'h5678, 1'b0, 5'b00000);
    send(OP_ARSH,  16'h8000, 16'h0014, 1'b0, 5'b00000);
    send(OP_LSH,   16'h0001, 16'h0010, 1'b0, 5'b00000);
    send(OP_ADDU,  16'hFFFF, 16'hFFFF, 1'b0, 5'b00000);
    send(OP_ADDCU, 16'h0000, 16'h0000, 1'b0, 5'b00000);
    send(OP_ADD,   16'h7FFF, 16'h0001, 1'b0, 5'b00000);
    send(OP_RSH,   16'h8000, 16'h000F, 1'b0, 5'b00000);
    send(OP_XOR,   16'hA5A5, 16'hA5A5, 1'b0, 5'b00000);
    send(4'b0000,  16'h0001, 16'h0001, 1'b0, 5'b00000);

    // MUL latency: busy through E+15, result and ready at E+16; inputs change meanwhile.
    send(OP_MUL, 16'h0003, 16'h0005, 1'b0, 5'b00000);
    a = 16'hDEAD;
    b = 16'hBEEF;
    opcode = OP_AND;
    chk("mul_busy_e0", {31'b0, in_ready}, 32'h0);
    for (int k = 1; k < 16; k++) begin
      @(posedge clk); #1;
      chk("mul_busy", {31'b0, in_ready}, 32'h0);
      chk("mul_no_early_ov", {31'b0, out_valid}, 32'h0);
    end
    @(posedge clk); #1;
    chk("mul_done_ov", {31'b0, out_valid}, 32'h1);
    chk("mul_ready_after", {31'b0, in_ready}, 32'h1);

    send(OP_MUL, 16'hFFFF, 16'h0002, 1'b0, 5'b00000);

    // Reset five edges into a multiply aborts it without a late pulse.
    send(OP_MUL, 16'h1234, 16'h0042, 1'b0, 5'b00000);
    repeat (4) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_result", {16'h0000, result}, 32'h0);
    chk("abort_flags", {27'h0, flags}, 32'h0);
    chk("abort_out_valid", {31'b0, out_valid}, 32'h0);
    sbq.delete();
    model_flags = 5'b00000;
    ov_before = ov_count;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("abort_ready", {31'b0, in_ready}, 32'h1);
    @(posedge clk); #1;
    chk("abort_ready_cyc1", {31'b0, in_ready}, 32'h1);
    repeat (24) @(posedge clk);
    #1;
    chk("abort_no_ov", ov_count, ov_before);

    send(OP_AND, 16'hF0F0, 16'h3C3C, 1'b1, 5'b01000);
    send(OP_OR,  16'h0000, 16'h0000, 1'b0, 5'b00000);

    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 15));
      rx  = 16'($urandom);
      if ($urandom_range(0, 3) == 0) ry = 16'($urandom_range(0, 20));
      else ry = 16'($urandom);
      send(rop, rx, ry, 1'b0, 5'b00000);
    end

    guard = 0;
    while (sbq.size() != 0 && guard < 100) begin
      @(posedge clk);
      guard++;
    end
    #1;
    chk("drain", sbq.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath width in bits (>= 4, power of 2).
REQ-002 SHALL have parameter MUL_EN, default 1, 1 = MUL opcode implemented, 0 = MUL treated as illegal.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operation request.
REQ-006 in_ready  output  1  block accepts a request this cycle.
REQ-007 a, b  input  WIDTH  operands.
REQ-008 opcode  input  4  operation select.
REQ-009 psr_we  input  1  write psr_wdata into the flag register.
REQ-010 psr_wdata  input  5  flag restore value.
REQ-011 out_valid  output  1  one-cycle pulse, result and flags valid.
REQ-012 result  output  WIDTH  registered result.
REQ-013 flags  output  5  registered flag register: [0] N, [1] L, [2] F (signed overflow), [3] C, [4] Z.

Function
REQ-014 Acceptance SHALL occur at an edge where in_valid and in_ready are both 1; in_ready SHALL be 1 exactly when the state is IDLE.
REQ-015 Opcodes SHALL be: AND 0001, OR 0010, XOR 0011, ADDCU 0100, ADD 0101, ADDU 0110, ADDC 0111, MUL 1000, SUB 1001, CMP 1011, LSH 1100, RSH 1101, ALSH 1110, ARSH 1111; 0000 and 1010 are illegal.
REQ-016 All non-MUL opcodes SHALL complete with result, flags and out_valid registered at the acceptance edge (latency 1).
REQ-017 ADDU/ADDCU SHALL produce a+b (+ registered C for ADDCU); C = carry-out, Z = (result==0), N, L, F = 0.
REQ-018 ADD/ADDC SHALL produce a+b (+ registered C for ADDC); F = signed overflow, Z = (result==0), N, L, C = 0.
REQ-019 SUB SHALL produce a-b; F = (a[MSB]!=b[MSB]) & (result[MSB]!=a[MSB]); Z = (result==0); N, L, C = 0.
REQ-020 CMP SHALL produce result 0; N = signed a<b, L = unsigned a<b, Z = (a==b), F, C = 0.
REQ-021 AND/OR/XOR SHALL set Z = (result==0) and clear N, L, F, C.
REQ-022 Shifts SHALL use the full b as amount; b >= WIDTH gives 0 for LSH/RSH/ALSH and WIDTH copies of a[MSB] for ARSH; all flags cleared.
REQ-023 MUL SHALL compute the low WIDTH bits of unsigned a*b by shift-add, one bit per cycle: state MUL entered at acceptance edge E, iterations at edges E+1..E+WIDTH, result/out_valid registered at edge E+WIDTH, state returns to IDLE at that edge.
REQ-024 MUL flags: Z = (low half==0), C = (high half!=0), N, L, F = 0.
REQ-025 Illegal opcode SHALL register result 0, leave flags unchanged, pulse out_valid.
REQ-026 out_valid SHALL be high for exactly one cycle per accepted operation; no backpressure on output.
REQ-027 Operands and opcode SHALL be sampled only at acceptance; input changes during MUL have no effect.
REQ-028 psr_we SHALL load psr_wdata into flags at the edge; if an operation completes on the same edge, psr_we wins for flags, result still updates.
REQ-029 Back-to-back single-cycle operations SHALL be accepted every cycle; ADDC/ADDCU SHALL see C written by the preceding operation.

Reset
REQ-030 reset_n low SHALL immediately force result = 0, flags = 0, out_valid = 0, state = IDLE, multiplier counter/accumulator = 0.
REQ-031 Reset during MUL SHALL abort it with no out_valid pulse after release; in_ready = 1 in the first cycle after release.

Structure
REQ-032 Package alu_pkg SHALL hold opcode constants, flag bit indices and the IDLE/MUL state encoding.
REQ-033 The iterative multiplier SHALL be sub-module alu_mul_iter (start, a, b -> done, product) instantiated when MUL_EN = 1.

Verification
REQ-034 Reset then ADDU a=FFFF b=0001 -> next cycle result 0000, flags C=1 Z=1; then ADDC a=0001 b=0001 -> result 0003, C=0.
REQ-035 SUB a=8000 b=0001 -> result 7FFF, F=1; CMP a=FFFF b=0001 -> N=1, L=0, Z=0, result 0.
REQ-036 MUL a=0003 b=0005 accepted at E -> in_ready low E..E+15, out_valid at E+16 with result 000F; MUL a=FFFF b=0002 -> result FFFE, C=1.
REQ-037 ARSH a=8000 b=0014 -> result FFFF; LSH a=0001 b=0010 -> result 0000.
REQ-038 reset_n pulsed low at E+5 of MUL -> outputs zero, no out_valid, in_ready high after release.
REQ-039 psr_we=1 psr_wdata=01000 on same edge as AND completing -> flags 01000, result = AND value, out_valid = 1.
